// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU control path.
//   OP_*    : opcode values carried in IR[7:6]
//   state_t : control FSM state encoding (3-bit)
//   sext2   : sign-extends the 2-bit immediate field to 8 bits
package cpu8_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    function automatic logic [7:0] sext2(input logic [1:0] v);
        return {{6{v[1]}}, v};
    endfunction

endpackage

// File: rtl/cpu8_multicycle_ctrl_if.sv
// Handshaked data-memory bus between the control unit and data memory.
//   Mem_Req   : request, held until Mem_Ack
//   Mem_We    : 1 = store, 0 = load (valid while Mem_Req)
//   Mem_Addr  : effective address (valid while Mem_Req)
//   Mem_Wdata : store data (valid while Mem_Req)
//   Mem_Ack   : completion, only meaningful while Mem_Req
//   Mem_Rdata : load data, valid with Mem_Ack
// master = control unit side, slave = memory side.
interface cpu8_multicycle_ctrl_if;
    logic       Mem_Req;
    logic       Mem_We;
    logic [7:0] Mem_Addr;
    logic [7:0] Mem_Wdata;
    logic       Mem_Ack;
    logic [7:0] Mem_Rdata;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        input  Mem_Ack, Mem_Rdata
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        output Mem_Ack, Mem_Rdata
    );
endinterface

// File: rtl/cpu8_agu.sv
// Single 8-bit adder shared by add, load/store effective address and jump
// target. Operands are selected from the opcode:
//   add   : rs + rt
//   lw/sw : rs + sext(f)
//   j     : pc + sext(f) + 1 (the +1 comes in as carry-in)
// Ports: op_i (opcode), pc_i, rs_i, rt_i (operands), f_i (immediate),
//        sum_o (8-bit result, carry discarded).
module cpu8_agu (
    input  logic [1:0] op_i,
    input  logic [7:0] pc_i,
    input  logic [7:0] rs_i,
    input  logic [7:0] rt_i,
    input  logic [1:0] f_i,
    output logic [7:0] sum_o
);
    import cpu8_pkg::*;

    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    always_comb begin
        a   = rs_i;
        b   = rt_i;
        cin = 1'b0;
        case (op_i)
            OP_LW, OP_SW: b = sext2(f_i);
            OP_J: begin
                a   = pc_i;
                b   = sext2(f_i);
                cin = 1'b1;
            end
            default: ;
        endcase
        sum_o = a + b + {7'b0, cin};
    end
endmodule

// File: rtl/cpu8_multicycle_ctrl.sv
// Multi-cycle control unit for the 8-bit, 4-opcode CPU (add/lw/sw/j).
// Owns the PC, sequences register file reads/writes and the handshaked
// data memory. FSM: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}, plus
// HALT and FAULT (both exit only by reset).
// Ports:
//   Clk, Reset_n              clock, async active-low reset
//   Pc / Instruction          instruction address / combinational byte
//   Rs_Addr, Rt_Addr          register read indices from IR
//   Rs_Data, Rt_Data          register read data
//   Wb_En, Wb_Addr, Wb_Data   one-cycle register write strobe
//   dmem                      data memory bus (master modport)
//   Halted                    self-jump detected
//   Fault                     sticky memory-timeout indicator
// Parameters: RESET_PC (reset PC), ACK_TIMEOUT (MEM wait limit, 0 = none).
// Build option: define CPU8_HALT_DETECT_EN to stop on j with f=2'b11.
module cpu8_multicycle_ctrl #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    output logic [7:0]                    Pc,
    input  logic [7:0]                    Instruction,
    output logic [1:0]                    Rs_Addr,
    output logic [1:0]                    Rt_Addr,
    input  logic [7:0]                    Rs_Data,
    input  logic [7:0]                    Rt_Data,
    output logic                          Wb_En,
    output logic [1:0]                    Wb_Addr,
    output logic [7:0]                    Wb_Data,
    cpu8_multicycle_ctrl_if.master        dmem,
    output logic                          Halted,
    output logic                          Fault
);
    import cpu8_pkg::*;

    state_t      state_q, state_d;
    logic [7:0]  pc_q,    pc_d;
    logic [7:0]  ir_q,    ir_d;
    logic [7:0]  rs_q,    rs_d;
    logic [7:0]  rt_q,    rt_d;
    logic [7:0]  res_q,   res_d;   // sum, effective address, then load data
    logic [15:0] wait_q,  wait_d;

    logic [1:0]  op;
    logic [7:0]  agu_sum;
    logic [7:0]  pc_inc;

    assign op     = ir_q[7:6];
    assign pc_inc = pc_q + 8'd1;

    cpu8_agu u_agu (
        .op_i  (op),
        .pc_i  (pc_q),
        .rs_i  (rs_q),
        .rt_i  (rt_q),
        .f_i   (ir_q[1:0]),
        .sum_o (agu_sum)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            res_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            res_q   <= res_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        res_d   = res_q;
        wait_d  = wait_q;

        case (state_q)
            S_FETCH: begin
                ir_d    = Instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                rs_d    = Rs_Data;
                rt_d    = Rt_Data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        res_d   = agu_sum;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        res_d   = agu_sum;
                        wait_d  = '0;
                        state_d = S_MEM;
                    end
                    default: begin
`ifdef CPU8_HALT_DETECT_EN
                        // f=2'b11 makes the target equal to the current PC
                        if (ir_q[1:0] == 2'b11) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = agu_sum;
                            state_d = S_FETCH;
                        end
`else
                        pc_d    = agu_sum;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                if (dmem.Mem_Ack) begin
                    if (op == OP_LW) begin
                        res_d   = dmem.Mem_Rdata;
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                    // wait_q counts MEM cycles already spent without an ack
                    if (ACK_TIMEOUT != 0 && wait_q == 16'(ACK_TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs decode from the state register so an async reset clears them at once.
    always_comb begin
        Pc             = pc_q;
        Rs_Addr        = ir_q[5:4];
        Rt_Addr        = ir_q[3:2];
        Wb_En          = 1'b0;
        Wb_Addr        = '0;
        Wb_Data        = '0;
        dmem.Mem_Req   = 1'b0;
        dmem.Mem_We    = 1'b0;
        dmem.Mem_Addr  = '0;
        dmem.Mem_Wdata = '0;
        Fault          = (state_q == S_FAULT);
`ifdef CPU8_HALT_DETECT_EN
        Halted         = (state_q == S_HALT);
`else
        Halted         = 1'b0;
`endif
        if (state_q == S_MEM) begin
            dmem.Mem_Req   = 1'b1;
            dmem.Mem_We    = (op == OP_SW);
            dmem.Mem_Addr  = res_q;
            dmem.Mem_Wdata = rt_q;
        end
        if (state_q == S_WB) begin
            Wb_En   = 1'b1;
            Wb_Addr = (op == OP_LW) ? ir_q[3:2] : ir_q[1:0];
            Wb_Data = res_q;
        end
    end

endmodule
